piso_stream_ser: RTL

Parametrised parallel-in/serial-out serializer that supersedes the fixed 4-bit load/shift PISO.
- Adds a valid/ready input handshake.
- A one-entry holding buffer lets back-to-back words stream out with no idle gap.
- Shift direction is selectable, and a shift_en strobe paces the output.
- Frame markers are provided for downstream framing or line encoders.
- Sits between a word-oriented producer and a bit-serial link.

---
 rtl/piso_pkg.sv | 17 +
 rtl/piso_hold_buf.sv | 37 +++
 rtl/piso_stream_ser.sv | 114 +++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared state type and sizing helper for the PISO stream serializer
// Contents:
//   piso_state_t : serializer FSM states (ST_IDLE, ST_SHIFT)
//   piso_cnt_w() : bit-counter width for a given word width
package piso_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } piso_state_t;

   // Counter must index bits 0..width-1; never narrower than one bit.
   function automatic int piso_cnt_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// rtl/piso_hold_buf.sv - one-entry holding buffer in front of the shift register
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : producer handshake; in_ready depends on registers only
//   in_data              : word captured on accept
//   drain                : consumer takes hold_data this cycle
//   hold_valid/hold_data : buffered word
module piso_hold_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             drain,
   output logic             hold_valid,
   output logic [WIDTH-1:0] hold_data
);

   assign in_ready = !hold_valid;

   // Accept and drain are mutually exclusive: accept needs an empty buffer,
   // drain needs a full one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (in_valid && in_ready) begin
         hold_valid <= 1'b1;
         hold_data  <= in_data;
      end else if (drain) begin
         hold_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/piso_stream_ser.sv
// rtl/piso_stream_ser.sv - parametrised parallel-in/serial-out stream serializer
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : word handshake; in_data captured on accept
//   in_data [WIDTH]       : parallel word
//   shift_en              : bit-rate strobe, consumes the current bit
//   ser_out               : serial data, IDLE_LEVEL outside a frame
//   ser_valid             : current bit consumed this cycle
//   frame_start/frame_end : level markers for first/last bit of a frame
//   busy                  : frame active or holding buffer full
module piso_stream_ser
   import piso_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             shift_en,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             frame_end,
   output logic             busy
);

   localparam int               CNT_W    = piso_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   piso_state_t      state, state_nxt;
   logic [WIDTH-1:0] sr, sr_nxt, sr_shifted;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             hold_valid;
   logic [WIDTH-1:0] hold_data;
   logic             drain;
   logic             out_bit;

   piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .drain      (drain),
      .hold_valid (hold_valid),
      .hold_data  (hold_data)
   );

   // The output end of sr is always the bit on the line; shifting moves the
   // next bit into that position.
   assign out_bit    = MSB_FIRST ? sr[WIDTH-1] : sr[0];
   assign sr_shifted = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
   assign busy       = (state == ST_SHIFT) | hold_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         sr    <= sr_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      sr_nxt      = sr;
      cnt_nxt     = cnt;
      drain       = 1'b0;
      ser_out     = IDLE_LEVEL;
      ser_valid   = 1'b0;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (hold_valid) begin
               drain     = 1'b1;
               sr_nxt    = hold_data;
               cnt_nxt   = '0;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            ser_out     = out_bit;
            ser_valid   = shift_en;
            frame_start = (cnt == '0);
            frame_end   = (cnt == CNT_LAST);
            if (shift_en) begin
               if (cnt == CNT_LAST) begin
                  // Reload straight from hold so the next frame follows with no gap.
                  if (hold_valid) begin
                     drain   = 1'b1;
                     sr_nxt  = hold_data;
                     cnt_nxt = '0;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end else begin
                  sr_nxt  = sr_shifted;
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
